// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at issue, parked in pending registers, and committed after a fixed latency.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [31:0] p_hi_r, p_hi_s;
    logic [31:0] p_lo_r, p_lo_s;
    logic [63:0] res_s;
    logic [31:0] b_nz_s;

    // Signed 32x32 product: sign-extended operands give the exact product modulo 2^64.
    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        return {{32{x[31]}}, x} * {{32{y[31]}}, y};
    endfunction

    // Signed divide on magnitudes, returns {remainder, quotient}; y must be nonzero.
    function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        mx = x[31] ? (32'd0 - x) : x;
        my = y[31] ? (32'd0 - y) : y;
        q  = mx / my;
        r  = mx % my;
        if (x[31] ^ y[31]) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (x[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    // Result of the long operation presented this cycle, as {hi, lo}.
    always_comb begin
        res_s  = {hi_r, lo_r};
        b_nz_s = (B == 32'd0) ? 32'd1 : B;
        case (md_op)
            OP_MULT:  res_s = smul(A, B);
            OP_MULTU: res_s = {32'd0, A} * {32'd0, B};
            OP_MSUB:  res_s = {hi_r, lo_r} - smul(A, B);
            OP_DIV:   res_s = (B == 32'd0) ? {hi_r, lo_r} : sdiv(A, b_nz_s);
            OP_DIVU:  res_s = (B == 32'd0) ? {hi_r, lo_r} : {A % b_nz_s, A / b_nz_s};
            default:  res_s = {hi_r, lo_r};
        endcase
    end

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        p_hi_s  = p_hi_r;
        p_lo_s  = p_lo_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU, OP_MSUB: begin
                            p_hi_s  = res_s[63:32];
                            p_lo_s  = res_s[31:0];
                            cnt_s   = MULT_LOAD;
                            state_s = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            p_hi_s  = res_s[63:32];
                            p_lo_s  = res_s[31:0];
                            cnt_s   = DIV_LOAD;
                            state_s = RUN;
                        end
                        OP_MTHI: hi_s = A;
                        OP_MTLO: lo_s = A;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Any start seen here is dropped; the stall unit keeps it from happening.
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    hi_s    = p_hi_r;
                    lo_s    = p_lo_r;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and HI/LO registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            p_hi_r  <= 32'd0;
            p_lo_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            p_hi_r  <= p_hi_s;
            p_lo_r  <= p_lo_s;
        end
    end

    assign busy = (state_r == RUN);
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against a wide-integer arithmetic model of HI/LO.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        busy_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    logic [31:0] hi_m;
    logic [31:0] lo_m;
    int          n_pass;
    int          n_total;

    muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (a_s),
        .B     (b_s),
        .busy  (busy_s),
        .HI    (hi_s),
        .LO    (lo_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural values.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
        int              ia;
        int              ib;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned acc;
        ia = int'(a);
        ib = int'(b);
        sa = ia;
        sb = ib;
        nhi = hi;
        nlo = lo;
        lat = 0;
        case (op)
            3'd1: begin acc = longint'(sa * sb); lat = MULT_N; end
            3'd2: begin acc = longint'(a) * longint'(b); lat = MULT_N; end
            3'd7: begin acc = {hi, lo} - longint'(sa * sb); lat = MULT_N; end
            3'd3: begin
                lat = DIV_N;
                acc = {hi, lo};
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    acc = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                lat = DIV_N;
                acc = {hi, lo};
                if (b != 32'd0) acc = {a % b, a / b};
            end
            3'd5: begin acc = {a, lo}; end
            3'd6: begin acc = {hi, a}; end
            default: acc = {hi, lo};
        endcase
        nhi = acc[63:32];
        nlo = acc[31:0];
    endfunction

    // Issue one op; optionally inject a start at busy cycle inj_at (must be ignored).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [2:0] inj_op, input logic [31:0] inj_a);
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
        int          cycles;
        bit          hold_ok;
        model(op, a, b, hi_m, lo_m, ehi, elo, lat);
        start = 1'b1; md_op = op; a_s = a; b_s = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        if (lat > 0) begin
            check_eq("busy_rise", 64'(busy_s), 64'd1);
            cycles  = 0;
            hold_ok = 1'b1;
            while (busy_s && cycles < 40) begin
                if (hi_s !== hi_m || lo_s !== lo_m) hold_ok = 1'b0;
                if (cycles + 1 == inj_at) begin
                    start = 1'b1; md_op = inj_op; a_s = inj_a;
                end
                @(posedge clk); #1;
                start = 1'b0; md_op = 3'd0;
                cycles++;
            end
            check_eq("busy_cycles", 64'(cycles), 64'(lat));
            check_eq("hold_while_busy", 64'(hold_ok), 64'd1);
        end else begin
            check_eq("no_busy", 64'(busy_s), 64'd0);
        end
        check_eq("hi", 64'(hi_s), 64'(ehi));
        check_eq("lo", 64'(lo_s), 64'(elo));
        hi_m = ehi;
        lo_m = elo;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
            2:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        hi_m    = 32'd0;
        lo_m    = 32'd0;
        reset   = 1'b1;
        start   = 1'b0;
        md_op   = 3'd0;
        a_s     = 32'd0;
        b_s     = 32'd0;
        #12 reset = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_busy", 64'(busy_s), 64'd0);
        check_eq("reset_hi", 64'(hi_s), 64'd0);
        check_eq("reset_lo", 64'(lo_s), 64'd0);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0, 3'd0, 32'd0);
        check_eq("mult_neg3x5", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 32'd0);
        check_eq("multu", {hi_s, lo_s}, 64'h0000_0001_FFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0);
        check_eq("div_neg7_2", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd4, 32'd7, 32'd2, 0, 3'd0, 32'd0);
        check_eq("divu_7_2", {hi_s, lo_s}, 64'h0000_0001_0000_0003);
        run_op(3'd5, 32'h11, 32'd0, 0, 3'd0, 32'd0);
        run_op(3'd6, 32'h22, 32'd0, 0, 3'd0, 32'd0);
        run_op(3'd3, 32'd100, 32'd0, 0, 3'd0, 32'd0);
        check_eq("div_by_zero", {hi_s, lo_s}, 64'h0000_0011_0000_0022);
        run_op(3'd6, 32'd10, 32'd0, 0, 3'd0, 32'd0);
        run_op(3'd5, 32'd0, 32'd0, 0, 3'd0, 32'd0);
        run_op(3'd7, 32'd3, 32'd4, 2, 3'd5, 32'h55);
        check_eq("msub_ignore_mthi", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        run_op(3'd0, 32'd1, 32'd1, 0, 3'd0, 32'd0);

        // Asynchronous reset in the middle of busy cycle 4 of a divide.
        start = 1'b1; md_op = 3'd3; a_s = 32'd50; b_s = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("pre_reset_busy", 64'(busy_s), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_busy", 64'(busy_s), 64'd0);
        check_eq("async_reset_hilo", {hi_s, lo_s}, 64'd0);
        #1 reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        repeat (12) begin @(posedge clk); #1; end
        check_eq("no_commit_after_reset", {31'd0, busy_s, hi_s, lo_s}, 64'd0);
        run_op(3'd1, 32'd2, 32'd3, 0, 3'd0, 32'd0);
        check_eq("mult_after_reset", {hi_s, lo_s}, 64'd6);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = pick_val();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
            run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 12),
                   3'($urandom_range(1, 7)), 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU. It accepts one mult/multu/div/divu/msub operation per issue and holds `busy` for a fixed latency before committing HI/LO. It executes mthi/mtlo writes in a single cycle. The hazard/stall unit consumes `busy` to freeze later HI/LO-using instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu/msub (legal 1–15).
- `DIV_CYCLES`, default 10: busy duration for div/divu (legal 1–15).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: E-stage instruction is an HI/LO operation; sampled at the rising edge.
- `md_op` input 3: operation code.
  - 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 msub.
  - 0 = none; ignored even with `start`.
- `A` input 32: rs operand, forwarded value.
- `B` input 32: rt operand, forwarded value.
- `busy` output 1: long operation in progress.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter `cnt` (4 bits) active.
- IDLE, `start`=1, `md_op` ∈ {1,2,3,4,7}:
  - Compute the result from `A`, `B` and current HI/LO; latch it into pending registers `p_hi`/`p_lo`.
  - Load `cnt` = MULT_CYCLES−1 (mult/multu/msub) or DIV_CYCLES−1 (div/divu).
  - Go to RUN.
- IDLE, `start`=1, `md_op`=5: HI ← A at that edge. `md_op`=6: LO ← A at that edge. No busy.
- RUN, `cnt`≠0: `cnt` decrements each edge.
- RUN, `cnt`=0: at the next edge, HI ← `p_hi`, LO ← `p_lo`, go to IDLE.
- Arithmetic:
  - mult: {HI,LO} = $signed(A)·$signed(B), 64-bit.
  - multu: {HI,LO} = A·B unsigned, 64-bit.
  - msub: {HI,LO} = {HI,LO} − $signed(A)·$signed(B), 64-bit wrap, using HI/LO as of the start edge.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
  - divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero: still takes DIV_CYCLES busy; HI/LO unchanged at commit (`p_hi`/`p_lo` loaded with current HI/LO).
- `start` while in RUN: ignored completely, including mthi/mtlo. The stall unit guarantees this does not happen; the bench checks the ignore.
- Reset (any time, including mid-RUN): state IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, pending result discarded.
- HI/LO change only at a commit edge, an mthi/mtlo edge, or reset.

## Timing
- Start sampled at edge k. `busy` goes 1 after edge k.
- `busy` stays 1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) and falls after edge k+N.
- HI/LO show the new value after edge k+N, the same edge `busy` falls.
- A mfhi/mflo in D during cycle k+N+1 reads the new value.
- A new `start` at edge k+N+1 is accepted (back-to-back with one idle edge). A `start` at edge k+N is in RUN and is ignored.
- mthi/mtlo: HI/LO updated at edge k, visible next cycle; `busy` never asserts.
- `busy` is registered (a state decode), not combinational from `start`. The stall unit covers the issue cycle separately via its E-stage decode.
- Reset values: `busy`=0, `HI`=0, `LO`=0.

## Test plan
- mult, A=0xFFFFFFFD (−3), B=5, default params:
  - `busy`=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - HI/LO hold their old values while busy.
- multu, A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div, A=0xFFFFFFF9 (−7), B=2:
  - `busy` for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=2: LO=3, HI=1.
- div by zero, B=0, starting from HI=0x11, LO=0x22: 10 busy cycles, then HI=0x11, LO=0x22.
- mtlo, A=10, then mthi, A=0, then msub, A=3, B=4:
  - After 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - mthi with A=0x55 issued at busy cycle 2 is ignored: HI ends 0xFFFFFFFF.
- Reset:
  - div started, `reset` pulsed asynchronously mid-cycle at busy cycle 4: `busy`=0, HI=LO=0 immediately; no commit afterwards.
  - A subsequent mult, A=2, B=3, gives LO=6 after 5 cycles.
